uart_cmd_ctrl: RTL and testbench
================================

// Module: uart_cmd_ctrl
// PURPOSE
// - Stopwatch command controller between UART RX/TX FIFOs and the stopwatch core.
// - Pops command bytes from the RX FIFO and arbitrates them against the run/clear buttons.
// - Sequences the STOP/RUN/CLEAR mode that drives the stopwatch core.
// - Pushes an acknowledge byte per command into the TX FIFO, honouring full back-pressure.
// PARAMETERS
// - ECHO_EN     1  1: write an ack byte per command; 0: no TX writes (o_tx_wr tied 0)
// - CLR_CYCLES  4  minimum cycles o_clr_on stays high per clear (>=1)
// PORTS
// - clk          in   1  system clock; all logic on posedge
// - reset        in   1  asynchronous, active-low reset
// - i_rx_empty   in   1  RX FIFO empty
// - i_rx_data    in   8  RX FIFO head byte (first-word-fall-through; valid while !i_rx_empty)
// - o_rx_rd      out  1  RX FIFO pop, one cycle per byte
// - i_tx_full    in   1  TX FIFO full
// - o_tx_wr      out  1  TX FIFO push
// - o_tx_data    out  8  ack byte, valid with o_tx_wr
// - i_btn_run    in   1  debounced one-cycle pulse, run/stop toggle
// - i_btn_clr    in   1  debounced level, clear request
// - o_run_on     out  1  stopwatch counting
// - o_clr_on     out  1  stopwatch clear
// BEHAVIOUR
// - Reset (reset==0, async) forces mode=STOP, cmd FSM=C_IDLE, clear counter=0, and all outputs=0.
// - Mode FSM (registered outputs: o_run_on = mode==RUN, o_clr_on = mode==CLEAR):
//   STOP : btn_run | cmd 'r' -> RUN; btn_clr | cmd 'c' -> CLEAR (counter loads CLR_CYCLES-1).
//   RUN  : btn_run | cmd 's' -> STOP; 'r' and 'c' are rejected; btn_clr is ignored.
//   CLEAR: counter decrements to 0; leaves to STOP when counter==0 and i_btn_clr==0.
//          All commands are rejected in CLEAR.
// - Command FSM:
//   C_IDLE: o_rx_rd = !i_rx_empty (combinational); on pop, latch i_rx_data into cmd_reg -> C_EXEC.
//   C_EXEC: one cycle; apply cmd_reg to the mode FSM; record accept/reject.
//           Next state is C_ACK if ECHO_EN, else C_IDLE.
//   C_ACK : if !i_tx_full, pulse o_tx_wr for one cycle -> C_IDLE; else hold o_tx_data and wait.
//           No new pop occurs while in C_EXEC or C_ACK.
// - Ack bytes:
//   'R' / 'S' / 'C' = accepted r / s / c.
//   '!' = valid command that is illegal in the current mode, or pre-empted by a button.
//   '?' = unknown byte (unknown bytes are consumed; mode is unchanged).
// - Arbitration: a button event in the same cycle as C_EXEC wins.
//   The button transition is applied and the UART command is rejected with ack '!'.
//   btn_run and btn_clr together in STOP: btn_clr wins.
// - Latency: byte at FIFO head with !empty at cycle 0 -> pop at cycle 0 -> mode change visible at cycle 2.
//   With TX not full, o_tx_wr is asserted at cycle 2; max throughput is one command per 3 cycles.
// - Case sensitive: only lowercase 'r', 's', 'c' are commands.
// - o_tx_data holds its last value when o_tx_wr==0.
// - Reset asserted mid-command: the command is discarded; no ack is sent after reset release.
// STRUCTURE
// - Shared package stopwatch_pkg holds:
//   mode encodings STP_MD=2'b00, RUN_MD=2'b01, CLR_MD=2'b10;
//   ASCII constants for 'r', 's', 'c', 'R', 'S', 'C', '!', '?'.
// - Sub-module cmd_decode: combinational byte -> {is_run, is_stop, is_clr, is_unknown}.
// - Top level holds the mode FSM, command FSM, clear counter ($clog2(CLR_CYCLES+1) bits) and TX data register.
// TESTING
// - Push "r" into the RX model -> o_rx_rd 1 cycle; o_run_on=1 at cycle 2; TX gets 'R' (0x52).
// - In RUN, push "c" then "s" -> TX gets '!' then 'S'; run stays 1 after 'c', drops after 's'.
// - In STOP, push "c" with btn_clr low -> o_clr_on high exactly 4 cycles, then STOP; TX gets 'C'.
//   Repeat with btn_clr held 10 cycles -> clear lasts until btn_clr falls.
// - Hold i_tx_full=1 and push "r","s" -> one pop only, o_tx_wr=0, mode=RUN.
//   Release full -> 'R' written, then 's' popped; TX then gets 'S'.
// - Pulse btn_run in the same cycle as C_EXEC of "r" in STOP -> mode RUN via button; TX gets '!'.
// - Push 0x41 -> ack '?' and mode unchanged.
//   Assert reset during C_ACK -> all outputs 0, no write after release.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch command path: mode codes, ASCII command/ack bytes
// and the decoded-command record.
package stopwatch_pkg;

  localparam logic [1:0] STP_MD = 2'b00;
  localparam logic [1:0] RUN_MD = 2'b01;
  localparam logic [1:0] CLR_MD = 2'b10;

  localparam logic [7:0] ASC_R_LO = 8'h72;  // 'r'
  localparam logic [7:0] ASC_S_LO = 8'h73;  // 's'
  localparam logic [7:0] ASC_C_LO = 8'h63;  // 'c'
  localparam logic [7:0] ASC_R_UP = 8'h52;  // 'R'
  localparam logic [7:0] ASC_S_UP = 8'h53;  // 'S'
  localparam logic [7:0] ASC_C_UP = 8'h43;  // 'C'
  localparam logic [7:0] ASC_BANG = 8'h21;  // '!'
  localparam logic [7:0] ASC_QM   = 8'h3F;  // '?'

  typedef struct packed {
    logic is_run;
    logic is_stop;
    logic is_clr;
    logic is_unknown;
  } cmd_dec_t;

endpackage

// File: rtl/cmd_decode.sv
// Combinational command byte classifier; only lowercase r/s/c are commands.
module cmd_decode
  import stopwatch_pkg::*;
(
  input  logic [7:0] i_byte,
  output cmd_dec_t   o_dec
);

  always_comb begin
    o_dec.is_run     = (i_byte == ASC_R_LO);
    o_dec.is_stop    = (i_byte == ASC_S_LO);
    o_dec.is_clr     = (i_byte == ASC_C_LO);
    o_dec.is_unknown = !(o_dec.is_run || o_dec.is_stop || o_dec.is_clr);
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Stopwatch command controller: pops UART command bytes, arbitrates them against the
// run/clear buttons, sequences STOP/RUN/CLEAR and pushes one ack byte per command.
module uart_cmd_ctrl
  import stopwatch_pkg::*;
#(
  parameter int ECHO_EN    = 1,
  parameter int CLR_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx_empty,
  input  logic [7:0] i_rx_data,
  output logic       o_rx_rd,
  input  logic       i_tx_full,
  output logic       o_tx_wr,
  output logic [7:0] o_tx_data,
  input  logic       i_btn_run,
  input  logic       i_btn_clr,
  output logic       o_run_on,
  output logic       o_clr_on
);

  localparam int              CNT_W    = $clog2(CLR_CYCLES + 1);
  localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLR_CYCLES - 1);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_EXEC = 2'd1;
  localparam logic [1:0] C_ACK  = 2'd2;

  logic [1:0]       r_mode;
  logic [1:0]       r_cstate;
  logic [CNT_W-1:0] r_clr_cnt;
  logic [7:0]       r_cmd;
  logic [7:0]       r_tx_data;
  logic             r_rx_en;

  cmd_dec_t         w_dec;
  logic             w_exec;
  logic             w_btn_evt;
  logic [1:0]       w_mode_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [7:0]       w_ack;

  cmd_decode u_cmd_decode (
    .i_byte (r_cmd),
    .o_dec  (w_dec)
  );

  // r_rx_en keeps the pop strobe low while reset is held.
  assign w_exec    = (r_cstate == C_EXEC);
  assign o_rx_rd   = r_rx_en && (r_cstate == C_IDLE) && !i_rx_empty;
  assign o_tx_wr   = (ECHO_EN != 0) && (r_cstate == C_ACK) && !i_tx_full;
  assign o_tx_data = r_tx_data;
  assign o_run_on  = (r_mode == RUN_MD);
  assign o_clr_on  = (r_mode == CLR_MD);

  // Buttons take priority over a UART command executing in the same cycle.
  always_comb begin
    w_btn_evt  = 1'b0;
    w_mode_nxt = r_mode;
    w_cnt_nxt  = r_clr_cnt;
    case (r_mode)
      STP_MD: begin
        w_btn_evt = i_btn_run | i_btn_clr;
        if (i_btn_clr || (w_exec && !i_btn_run && w_dec.is_clr)) begin
          w_mode_nxt = CLR_MD;
          w_cnt_nxt  = CLR_LOAD;
        end else if (i_btn_run || (w_exec && w_dec.is_run)) begin
          w_mode_nxt = RUN_MD;
        end
      end
      RUN_MD: begin
        w_btn_evt = i_btn_run;
        if (i_btn_run || (w_exec && w_dec.is_stop)) w_mode_nxt = STP_MD;
      end
      CLR_MD: begin
        if (r_clr_cnt != '0)  w_cnt_nxt  = r_clr_cnt - CNT_W'(1);
        else if (!i_btn_clr)  w_mode_nxt = STP_MD;
      end
      default: w_mode_nxt = STP_MD;
    endcase
  end

  always_comb begin
    w_ack = ASC_BANG;
    if (w_dec.is_unknown)                      w_ack = ASC_QM;
    else if (w_btn_evt)                        w_ack = ASC_BANG;
    else if (r_mode == STP_MD && w_dec.is_run) w_ack = ASC_R_UP;
    else if (r_mode == STP_MD && w_dec.is_clr) w_ack = ASC_C_UP;
    else if (r_mode == RUN_MD && w_dec.is_stop) w_ack = ASC_S_UP;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode    <= STP_MD;
      r_cstate  <= C_IDLE;
      r_clr_cnt <= '0;
      r_tx_data <= '0;
      r_rx_en   <= 1'b0;
    end else begin
      r_rx_en   <= 1'b1;
      r_mode    <= w_mode_nxt;
      r_clr_cnt <= w_cnt_nxt;
      case (r_cstate)
        C_IDLE: if (o_rx_rd) r_cstate <= C_EXEC;
        C_EXEC: begin
          r_cstate <= (ECHO_EN != 0) ? C_ACK : C_IDLE;
          if (ECHO_EN != 0) r_tx_data <= w_ack;
        end
        C_ACK:   if (!i_tx_full) r_cstate <= C_IDLE;
        default: r_cstate <= C_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (o_rx_rd) r_cmd <= i_rx_data;
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: directed scenarios plus random bytes/buttons/back-pressure
// against a cycle-level reference model of the command rules.
module tb_uart_cmd_ctrl;

  localparam int CLR_CYCLES = 4;
  localparam logic [7:0] CH_R = 8'h72, CH_S = 8'h73, CH_C = 8'h63;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i_rx_empty = 1'b1;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_tx_full = 1'b0;
  logic       i_btn_run = 1'b0;
  logic       i_btn_clr = 1'b0;
  logic       o_rx_rd, o_tx_wr, o_run_on, o_clr_on;
  logic [7:0] o_tx_data;

  uart_cmd_ctrl #(.ECHO_EN(1), .CLR_CYCLES(CLR_CYCLES)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_rx_empty (i_rx_empty),
    .i_rx_data  (i_rx_data),
    .o_rx_rd    (o_rx_rd),
    .i_tx_full  (i_tx_full),
    .o_tx_wr    (o_tx_wr),
    .o_tx_data  (o_tx_data),
    .i_btn_run  (i_btn_run),
    .i_btn_clr  (i_btn_clr),
    .o_run_on   (o_run_on),
    .o_clr_on   (o_clr_on)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] rxq[$];
  logic [7:0] exp_q[$];

  // reference model: mode 0=stop 1=run 2=clear; phase 0=idle 1=exec 2=ack
  int         m_mode = 0;
  int         m_phase = 0;
  int         m_age = 0;
  logic [7:0] m_cmd = 8'h00;

  logic drv_run = 1'b0, drv_clr = 1'b0, drv_full = 1'b0, drv_rst_n = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] expected_ack(input int mode, input logic [7:0] cmd, input logic evt);
    if (!(cmd == CH_R || cmd == CH_S || cmd == CH_C)) return 8'h3F;
    if (evt) return 8'h21;
    if (mode == 0 && cmd == CH_R) return 8'h52;
    if (mode == 0 && cmd == CH_C) return 8'h43;
    if (mode == 1 && cmd == CH_S) return 8'h53;
    return 8'h21;
  endfunction

  // One clock: drive at negedge, compare at +1, then advance the model to the next cycle.
  task automatic cycle();
    logic       empty;
    logic [7:0] head;
    logic       evt;
    int         nmode;
    @(negedge clk);
    reset     = drv_rst_n;
    i_btn_run = drv_run;
    i_btn_clr = drv_clr;
    i_tx_full = drv_full;
    if (!drv_rst_n) begin
      rxq.delete();
      exp_q.delete();
      m_mode  = 0;
      m_phase = 0;
      m_age   = 0;
    end
    empty      = (rxq.size() == 0);
    head       = empty ? 8'h00 : rxq[0];
    i_rx_empty = empty;
    i_rx_data  = head;
    #1;
    chk("rx_rd", o_rx_rd, drv_rst_n && m_phase == 0 && !empty);
    chk("tx_wr", o_tx_wr, drv_rst_n && m_phase == 2 && !drv_full);
    chk("run_on", o_run_on, m_mode == 1);
    chk("clr_on", o_clr_on, m_mode == 2);
    if (!drv_rst_n) chk("tx_data_rst", o_tx_data, 0);
    if (drv_rst_n) begin
      if (o_rx_rd === 1'b1) void'(rxq.pop_front());
      evt   = (m_mode == 0 && (drv_run || drv_clr)) || (m_mode == 1 && drv_run);
      nmode = m_mode;
      if (m_phase == 1) exp_q.push_back(expected_ack(m_mode, m_cmd, evt));
      case (m_mode)
        0: begin
          if (drv_clr)                          nmode = 2;
          else if (drv_run)                     nmode = 1;
          else if (m_phase == 1 && m_cmd == CH_C) nmode = 2;
          else if (m_phase == 1 && m_cmd == CH_R) nmode = 1;
        end
        1: if (drv_run || (m_phase == 1 && m_cmd == CH_S)) nmode = 0;
        default: if (m_age >= CLR_CYCLES && !drv_clr) nmode = 0;
      endcase
      if (nmode == 2) m_age = (m_mode == 2) ? m_age + 1 : 1;
      else            m_age = 0;
      m_mode = nmode;
      case (m_phase)
        0: if (!empty) begin m_cmd = head; m_phase = 1; end
        1: m_phase = 2;
        default: if (!drv_full) m_phase = 0;
      endcase
    end
    drv_run = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Monitor: every TX push must match the oldest outstanding expected ack.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (o_tx_wr === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got write of %0h expected no write at %0t", o_tx_data, $time);
        end else begin
          chk("tx_data", o_tx_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    drv_rst_n = 1'b0;
    run(3);
    drv_rst_n = 1'b1;
    run(2);

    // run command, then rejected clear and accepted stop
    rxq.push_back(CH_R); run(5);
    rxq.push_back(CH_C); run(4);
    rxq.push_back(CH_S); run(5);

    // clear for the minimum time, then with the button held
    rxq.push_back(CH_C); run(10);
    rxq.push_back(CH_C); run(1);
    drv_clr = 1'b1; run(10);
    drv_clr = 1'b0; run(8);

    // TX back-pressure holds the second command in the FIFO
    drv_full = 1'b1;
    rxq.push_back(CH_R); rxq.push_back(CH_S); run(8);
    drv_full = 1'b0; run(10);

    // button pre-empts a command in its execute cycle
    rxq.push_back(CH_R); run(1);
    drv_run = 1'b1; run(1);
    run(4);
    drv_run = 1'b1; run(3);

    // unknown byte, then reset while an ack is stalled
    rxq.push_back(8'h41); run(6);
    drv_full = 1'b1;
    rxq.push_back(CH_R); run(5);
    drv_rst_n = 1'b0; run(3);
    drv_rst_n = 1'b1; run(3);
    drv_full = 1'b0; run(6);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      if (rxq.size() < 2 && $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 5))
          0: b = CH_R;
          1: b = CH_S;
          2: b = CH_C;
          3: b = 8'h52;
          4: b = 8'h41;
          default: b = 8'($urandom);
        endcase
        rxq.push_back(b);
      end
      drv_full = ($urandom_range(0, 3) == 0);
      drv_run  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 24) == 0) drv_clr = !drv_clr;
      cycle();
    end

    drv_full = 1'b0;
    drv_clr  = 1'b0;
    run(40);
    chk("ack_drain", exp_q.size(), 0);
    chk("rx_drain", rxq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
